buffer_pool_manager: RTL
========================

# buffer_pool_manager

Parametrised N-buffer pool manager that coordinates one streaming writer (S2MM side) and one frame reader (software/MM2S side) over `NUM_BUFFERS` equally sized buffers in DDR. It supersedes the fixed four-buffer manager with a configurable buffer count and two hand-over modes:
- latest-frame: ready depth 1, the newest frame wins.
- queued: ready FIFO of depth `NUM_BUFFERS-2`, oldest dropped on overflow.

It also adds an explicit grant/freshness handshake and a drop counter. It sits between the S2MM address generator and the AXI-Lite register bank.

## Interface
- `MM_ADDR_WIDTH`, 32, byte-address width.
- `DATA_WIDTH`, 32, beat width in bits; a power of two, at least 8.
- `NUM_BUFFERS`, 4, buffer count; legal range 3..8.
- `MAX_LOG_LENGTH`, 20, upper bound for `cfg_log_length`.

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: reset, synchronous, active-low; clock `aclk`.
- `cfg_base_address` in `MM_ADDR_WIDTH`: byte address of buffer 0; static while out of reset.
- `cfg_log_length` in 5: buffer length = 2^n beats; static while out of reset; values above `MAX_LOG_LENGTH` are clamped.
- `cfg_mode` in 1: 0 = latest-frame, 1 = queued; static while out of reset.
- `wr_beat` in 1: writer completed one beat at `wr_address` this cycle.
- `wr_address` out `MM_ADDR_WIDTH`: byte address for the next writer beat.
- `rd_request` in 1: level; the reader asks for a new frame.
- `rd_grant` out 1: one-cycle pulse acknowledging a request.
- `rd_fresh` out 1: valid with `rd_grant`; 1 = a new frame was handed over.
- `rd_buffer` out `MM_ADDR_WIDTH`: byte address of the buffer the reader owns.
- `ready_count` out 4: number of completed frames waiting.
- `drop_count` out 16: frames discarded since reset; saturates at 0xFFFF.
- `owner_map` out 8: bit i = buffer i is owned by the reader, the writer or the ready queue (debug).

## Operation
- Buffer size in bytes: S = 2^len × `DATA_WIDTH`/8. Buffer i starts at `cfg_base_address` + i×S. All address arithmetic is `MM_ADDR_WIDTH`-wide and wraps modulo 2^`MM_ADDR_WIDTH`.
- Each buffer has exactly one role at any time: READ (exactly one), WRITE (exactly one), READY (0..Q), or FREE. Q = 1 in mode 0 and Q = `NUM_BUFFERS`-2 in mode 1.
- Reset state:
  - READ = 0, WRITE = 1, ready queue empty, `wr_count` = 0.
  - Outputs: `rd_grant` = 0, `rd_fresh` = 0, `ready_count` = 0, `drop_count` = 0.
  - `rd_buffer` = base, `wr_address` = base + S, `owner_map` = 0b11.
- Writer: `wr_address` = WRITE start + `wr_count`×`DATA_WIDTH`/8. Each `wr_beat` increments `wr_count`.
- Frame completion: a `wr_beat` with `wr_count` = 2^len−1.
  - `wr_count` returns to 0 and WRITE is pushed onto the ready queue.
  - If the queue already held Q entries, the oldest entry becomes FREE and `drop_count` increments.
  - The new WRITE is the lowest-index FREE buffer, evaluated after the push/drop. One always exists because `NUM_BUFFERS` ≥ Q+2.
- Reader request: a request event is a rising edge of `rd_request`, i.e. the current value is 1 and the registered previous value is 0. A held level produces exactly one event.
  - Queue non-empty: the old READ becomes FREE, the queue head becomes READ, and the grant carries `rd_fresh` = 1.
  - Queue empty: roles are unchanged and the grant carries `rd_fresh` = 0.
- Simultaneous completion and request event in the same cycle: the completion is applied first. The reader may therefore receive the frame that just completed, and the freed old READ is not eligible as the new WRITE in that cycle.

## Timing
- Request event in cycle k:
  - `rd_grant` = 1 and `rd_fresh` are valid in cycle k+1 (registered).
  - `rd_buffer` takes its new value in cycle k+1.
  - `rd_grant` returns to 0 in k+2.
- Frame completion in cycle k: `wr_address`, `ready_count`, `drop_count` and `owner_map` update in cycle k+1. `wr_address` advances by `DATA_WIDTH`/8 in the cycle after each non-completing `wr_beat`.
- `rd_request` asserted during reset: the edge detector's previous-value register holds 0 in reset, so a level still high in the first cycle after reset counts as one event.
- Reset mid-frame returns to the reset state. The partial frame is lost and is not counted in `drop_count`.
- Mode, length and base address changes take effect only through reset.

## Test plan
- Reset check, with `NUM_BUFFERS`=4, base 0x1000_0000, len 4 (S = 64): all reset values as listed; `wr_address` = 0x1000_0040; `rd_buffer` = 0x1000_0000.
- Mode 0, 32 beats then one request pulse:
  - Frames land in buffers 1 then 2; buffer 1 is dropped, so `drop_count` = 1.
  - Grant with `rd_fresh` = 1 and `rd_buffer` = 0x1000_0080.
  - `wr_address` = 0x1000_0040, reusing the freed buffer 1.
- Mode 1, 48 beats with no requests:
  - Queue holds 2 frames; `drop_count` = 1 with the oldest frame (buffer 1) dropped.
  - Three request pulses yield `rd_fresh` = 1, 1, 0.
  - `rd_buffer` stays put on the third grant.
- Request event in the same cycle as a frame completion with the queue empty: the grant in the next cycle has `rd_fresh` = 1 and `rd_buffer` = the just-completed buffer.
- `rd_request` held high for 100 cycles across two frame completions: exactly one `rd_grant` pulse.
- Reset asserted after 10 beats: all outputs return to their reset values and `drop_count` = 0.

Source files
------------

// File: rtl/buffer_pool_manager.sv
// N-buffer pool manager: hands completed S2MM frames to a single reader,
// in latest-frame mode (ready depth 1) or queued mode (ready depth NUM_BUFFERS-2).
module buffer_pool_manager #(
  parameter int MM_ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_BUFFERS    = 4,
  parameter int MAX_LOG_LENGTH = 20
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [MM_ADDR_WIDTH-1:0] cfg_base_address,
  input  logic [4:0]               cfg_log_length,
  input  logic                     cfg_mode,
  input  logic                     wr_beat,
  output logic [MM_ADDR_WIDTH-1:0] wr_address,
  input  logic                     rd_request,
  output logic                     rd_grant,
  output logic                     rd_fresh,
  output logic [MM_ADDR_WIDTH-1:0] rd_buffer,
  output logic [3:0]               ready_count,
  output logic [15:0]              drop_count,
  output logic [7:0]               owner_map
);

  localparam int IDX_W      = $clog2(NUM_BUFFERS);
  localparam int QMAX       = NUM_BUFFERS - 2;
  localparam int QC_W       = $clog2(QMAX + 1);
  localparam int CNT_W      = (MAX_LOG_LENGTH < 1) ? 1 : MAX_LOG_LENGTH;
  localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

  logic [IDX_W-1:0] read_idx_q, read_idx_d;
  logic [IDX_W-1:0] write_idx_q, write_idx_d;
  logic [CNT_W-1:0] wr_count_q, wr_count_d;
  logic [15:0]      drop_count_q, drop_count_d;
  logic [QC_W-1:0]  rq_cnt_q, rq_cnt_d;
  logic [IDX_W-1:0] rq_q [QMAX];
  logic [IDX_W-1:0] rq_d [QMAX];
  logic             rd_grant_q, rd_grant_d;
  logic             rd_fresh_q, rd_fresh_d;
  logic             req_prev_q, req_prev_d;

  logic [4:0]       len_eff;
  logic [5:0]       size_shift;
  logic [CNT_W-1:0] last_count;
  logic [QC_W-1:0]  q_limit;
  logic             frame_done;
  logic             req_event;
  logic [7:0]       busy;
  logic [IDX_W-1:0] free_idx;

  always_comb begin
    len_eff    = (cfg_log_length > 5'(MAX_LOG_LENGTH)) ? 5'(MAX_LOG_LENGTH) : cfg_log_length;
    size_shift = 6'(len_eff) + 6'(BYTE_SHIFT);
    last_count = CNT_W'((32'd1 << len_eff) - 32'd1);
    q_limit    = cfg_mode ? QC_W'(QMAX) : QC_W'(1);
    frame_done = wr_beat && (wr_count_q == last_count);
    req_event  = rd_request && !req_prev_q;
  end

  // Completion is applied before the request so a reader can take the frame
  // that just finished, and the READ being released is still busy when the
  // new WRITE is chosen.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    read_idx_d   = read_idx_q;
    write_idx_d  = write_idx_q;
    wr_count_d   = wr_count_q;
    drop_count_d = drop_count_q;
    rq_cnt_d     = rq_cnt_q;
    rq_d         = rq_q;
    rd_grant_d   = 1'b0;
    rd_fresh_d   = 1'b0;
    req_prev_d   = rd_request;
    busy         = '0;
    free_idx     = write_idx_q;

    if (wr_beat) begin
      wr_count_d = frame_done ? '0 : wr_count_q + CNT_W'(1);
    end

    if (frame_done) begin
      if (rq_cnt_d == q_limit) begin
        for (int i = 0; i < QMAX - 1; i++) rq_d[i] = rq_d[i+1];
        rq_cnt_d = rq_cnt_d - QC_W'(1);
        if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
      end
      for (int i = 0; i < QMAX; i++) begin
        if (QC_W'(i) == rq_cnt_d) rq_d[i] = write_idx_q;
      end
      rq_cnt_d = rq_cnt_d + QC_W'(1);

      busy[3'(read_idx_q)] = 1'b1;
      for (int i = 0; i < QMAX; i++) begin
        if (QC_W'(i) < rq_cnt_d) busy[3'(rq_d[i])] = 1'b1;
      end
      // Descending scan leaves the lowest free index as the winner.
      for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
        if (!busy[i]) free_idx = IDX_W'(i);
      end
      write_idx_d = free_idx;
    end

    if (req_event) begin
      rd_grant_d = 1'b1;
      if (rq_cnt_d != '0) begin
        rd_fresh_d = 1'b1;
        read_idx_d = rq_d[0];
        for (int i = 0; i < QMAX - 1; i++) rq_d[i] = rq_d[i+1];
        rq_cnt_d = rq_cnt_d - QC_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      read_idx_q   <= '0;
      write_idx_q  <= IDX_W'(1);
      wr_count_q   <= '0;
      drop_count_q <= '0;
      rq_cnt_q     <= '0;
      rd_grant_q   <= 1'b0;
      rd_fresh_q   <= 1'b0;
      req_prev_q   <= 1'b0;
    end else begin
      read_idx_q   <= read_idx_d;
      write_idx_q  <= write_idx_d;
      wr_count_q   <= wr_count_d;
      drop_count_q <= drop_count_d;
      rq_cnt_q     <= rq_cnt_d;
      rd_grant_q   <= rd_grant_d;
      rd_fresh_q   <= rd_fresh_d;
      req_prev_q   <= req_prev_d;
    end
  end

  // NOTE: queue storage is not reset; entries at or above rq_cnt_q are never read.
  always_ff @(posedge aclk) begin
    rq_q <= rq_d;
  end

  always_comb begin
    owner_map = '0;
    owner_map[3'(read_idx_q)]  = 1'b1;
    owner_map[3'(write_idx_q)] = 1'b1;
    for (int i = 0; i < QMAX; i++) begin
      if (QC_W'(i) < rq_cnt_q) owner_map[3'(rq_q[i])] = 1'b1;
    end
  end

  assign rd_buffer   = cfg_base_address + (MM_ADDR_WIDTH'(read_idx_q) << size_shift);
  assign wr_address  = cfg_base_address + (MM_ADDR_WIDTH'(write_idx_q) << size_shift)
                     + (MM_ADDR_WIDTH'(wr_count_q) << BYTE_SHIFT);
  assign ready_count = 4'(rq_cnt_q);
  assign drop_count  = drop_count_q;
  assign rd_grant    = rd_grant_q;
  assign rd_fresh    = rd_fresh_q;

endmodule
